stopwatch_ctrl: RTL and testbench

//  Run/pause/clear/adjust controller for the stopwatch counter datapath.

---
 rtl/stopwatch_ctrl_pkg.sv | 24 ++
 rtl/stopwatch_ctrl_btn_cond.sv | 53 +++++
 rtl/stopwatch_ctrl.sv | 95 +++++++++
 tb/tb_stopwatch_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: FSM state encoding and
// default conditioner timing used by the controller and the display mux.
package stopwatch_ctrl_pkg;

  // Default stability filter length and the counter width that must hold DB_CYCLES-1
  localparam int DB_CYCLES_DEF = 16;
  localparam int CNT_W_DEF     = 5;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSE  = 2'b10,
    ST_ADJUST = 2'b11
  } swState_e;

  // Transition taken on a pause press outside ADJUST
  function automatic swState_e pauseToggle(input swState_e cur);
    case (cur)
      ST_RUN:  pauseToggle = ST_PAUSE;
      default: pauseToggle = ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_cond.sv
// Input conditioner: two-flop synchroniser, stability filter and a
// registered rising-edge press pulse for one raw board input.
module btn_cond
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             stable;
  logic             stableD;
  logic [CNT_W-1:0] cnt;

  // A level change is accepted only after DB_CYCLES consecutive mismatching samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      stable  <= 1'b0;
      stableD <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      stableD <= stable;
      press   <= stable & ~stableD;
      if (s2 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear/adjust controller: conditions board inputs, sequences the
// stopwatch FSM and gates divider ticks into counter/adjust enables.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_pause,
  input  logic       btn_reset,
  input  logic       sw_adj,
  input  logic       sw_sel,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       adj_en,
  output logic       adj_sel,
  output logic       blink,
  output logic [1:0] state
);

  logic pauseLevel, pausePress;
  logic resetLevel, resetPress;
  logic adjLevel, adjPress;
  logic selLevel, selPress;
  logic unusedBits;

  swState_e curState;
  swState_e nextState;

  btn_cond #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) uPause (
    .clk(clk), .rst_n(rst_n), .raw(btn_pause), .level(pauseLevel), .press(pausePress)
  );

  btn_cond #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) uReset (
    .clk(clk), .rst_n(rst_n), .raw(btn_reset), .level(resetLevel), .press(resetPress)
  );

  btn_cond #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) uAdj (
    .clk(clk), .rst_n(rst_n), .raw(sw_adj), .level(adjLevel), .press(adjPress)
  );

  btn_cond #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) uSel (
    .clk(clk), .rst_n(rst_n), .raw(sw_sel), .level(selLevel), .press(selPress)
  );

  // Switches are used as levels and the clear button only as a press
  assign unusedBits = ^{adjPress, selPress, resetLevel};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curState <= ST_CLEAR;
    end else begin
      curState <= nextState;
    end
  end

  // Adjust switch dominates, then clear press, then pause press
  always_comb begin
    nextState = curState;
    if (adjLevel) begin
      nextState = ST_ADJUST;
    end else if (curState == ST_ADJUST) begin
      nextState = ST_PAUSE;
    end else if (resetPress) begin
      nextState = ST_CLEAR;
    end else if (pausePress) begin
      nextState = pauseToggle(curState);
    end
  end

  // Clear pulses on every accepted clear press, even while adjusting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_clr <= 1'b0;
      blink   <= 1'b0;
    end else begin
      cnt_clr <= resetPress;
      if (curState == ST_ADJUST && nextState == ST_ADJUST) begin
        blink <= blink ^ tick_2hz;
      end else begin
        blink <= 1'b0;
      end
    end
  end

  assign cnt_en  = tick_1hz & (curState == ST_RUN);
  assign adj_en  = tick_2hz & (curState == ST_ADJUST) & ~pauseLevel;
  assign adj_sel = selLevel;
  assign state   = curState;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed timing checks plus
// randomized inputs compared every cycle against a behavioural model.
module tb_stopwatch_ctrl;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_reset = 1'b0;
  logic       sw_adj = 1'b0;
  logic       sw_sel = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       tick_2hz = 1'b0;
  logic       cnt_en, cnt_clr, adj_en, adj_sel, blink;
  logic [1:0] state;

  int compared = 0;
  int mismatched = 0;
  bit checkEn = 1'b0;

  stopwatch_ctrl #(.DB_CYCLES(DB), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_pause(btn_pause), .btn_reset(btn_reset),
    .sw_adj(sw_adj), .sw_sel(sw_sel),
    .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .adj_en(adj_en),
    .adj_sel(adj_sel), .blink(blink), .state(state)
  );

  always #5 clk = ~clk;

  // Model: index 0 pause, 1 clear, 2 adjust switch, 3 select switch
  int mState;
  bit mBlink, mClr;
  bit mHist[4][DB+1];
  bit mStable[4];
  bit mPress[4];
  bit mRose[4];

  function automatic bit rawOf(input int i);
    case (i)
      0:       return btn_pause;
      1:       return btn_reset;
      2:       return sw_adj;
      default: return sw_sel;
    endcase
  endfunction

  function automatic int nextOf(input int s, input bit adj, input bit rp, input bit pp);
    if (adj) return 3;
    if (s == 3) return 2;
    if (rp) return 0;
    if (pp) return (s == 1) ? 2 : 1;
    return s;
  endfunction

  // A filtered level flips when the last DB synchronised samples all disagree with it
  always @(posedge clk or negedge rst_n) begin : modelBlk
    int nxt;
    bit allDiff;
    if (!rst_n) begin
      mState = 0;
      mBlink = 1'b0;
      mClr   = 1'b0;
      for (int i = 0; i < 4; i++) begin
        mStable[i] = 1'b0;
        mPress[i]  = 1'b0;
        mRose[i]   = 1'b0;
        for (int k = 0; k <= DB; k++) mHist[i][k] = 1'b0;
      end
    end else begin
      nxt    = nextOf(mState, mStable[2], mPress[1], mPress[0]);
      mBlink = (mState == 3 && nxt == 3) ? (mBlink ^ tick_2hz) : 1'b0;
      mClr   = mPress[1];
      mState = nxt;
      for (int i = 0; i < 4; i++) begin
        mPress[i] = mRose[i];
        allDiff = 1'b1;
        for (int k = 1; k <= DB; k++) if (mHist[i][k] == mStable[i]) allDiff = 1'b0;
        mRose[i] = allDiff && !mStable[i];
        if (allDiff) mStable[i] = !mStable[i];
        for (int k = DB; k >= 1; k--) mHist[i][k] = mHist[i][k-1];
        mHist[i][0] = rawOf(i);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit p, input bit r, input bit a, input bit s,
                               input bit t1, input bit t2);
    btn_pause = p;
    btn_reset = r;
    sw_adj    = a;
    sw_sel    = s;
    tick_1hz  = t1;
    tick_2hz  = t2;
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("state",   state,             2'(mState));
      checkOutput("cnt_en",  {1'b0, cnt_en},    {1'b0, tick_1hz && mState == 1});
      checkOutput("cnt_clr", {1'b0, cnt_clr},   {1'b0, mClr});
      checkOutput("adj_en",  {1'b0, adj_en},    {1'b0, tick_2hz && mState == 3 && !mStable[0]});
      checkOutput("adj_sel", {1'b0, adj_sel},   {1'b0, mStable[3]});
      checkOutput("blink",   {1'b0, blink},     {1'b0, mBlink});
    end
  end

  initial begin
    bit tgt[4];
    int bounce[4];
    bit rv[4];

    applyStimulus(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checkEn = 1'b1;

    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1 tick_1hz = (i % 5 == 0);
      @(negedge clk);
      if (i == 0) checkOutput("idle_cnt_en", {1'b0, cnt_en}, 2'd0);
    end
    checkOutput("idle_state", state, 2'b00);

    @(posedge clk);
    #1 applyStimulus(1, 0, 0, 0, 0, 0);
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 7) checkOutput("press_edge7_state", state, 2'b00);
      if (e == 8) checkOutput("press_edge8_state", state, 2'b01);
    end
    repeat (12) @(posedge clk);
    #1 btn_pause = 1'b0;
    repeat (12) @(posedge clk);
    #1 tick_1hz = 1'b1;
    @(negedge clk);
    checkOutput("run_cnt_en", {1'b0, cnt_en}, 2'd1);
    @(posedge clk);
    #1 applyStimulus(0, 1, 0, 0, 0, 0);
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 8) begin
        checkOutput("clr_state", state, 2'b00);
        checkOutput("clr_pulse", {1'b0, cnt_clr}, 2'd1);
      end
      if (e == 9) checkOutput("clr_pulse_end", {1'b0, cnt_clr}, 2'd0);
    end
    repeat (12) @(posedge clk);
    #1 btn_reset = 1'b0;
    repeat (12) @(posedge clk);

    #1 btn_pause = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 7) checkOutput("held_reset_edge7", state, 2'b00);
      if (e == 8) checkOutput("held_reset_edge8", state, 2'b01);
    end
    @(posedge clk);
    #1 btn_pause = 1'b0;
    repeat (12) @(posedge clk);

    for (int i = 0; i < 4; i++) begin
      tgt[i]    = 1'b0;
      bounce[i] = 0;
    end
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, (i < 2) ? 30 : 120) == 0) begin
          tgt[i]    = !tgt[i];
          bounce[i] = (i < 2) ? int'($urandom_range(0, 6)) : 0;
        end
        if (bounce[i] > 0) begin
          rv[i] = ($urandom_range(0, 1) == 1);
          bounce[i]--;
        end else begin
          rv[i] = tgt[i];
        end
      end
      applyStimulus(rv[0], rv[1], rv[2], rv[3],
                    $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 799) != 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
